sync_fifo_param: RTL and testbench

Parametrised single-clock FIFO. It replaces the fixed 8-bit by 16-entry FIFO in the codebase.
- Adds configurable width and depth, full/empty and programmable almost-full/almost-empty flags, an occupancy count, and overflow/underflow error pulses.
- Adds a synchronous flush and a selectable first-word-fall-through (FWFT) read mode.
- Sits between a producer and a consumer in the same clock domain.

---
 rtl/sync_fifo_param.sv | 109 ++++++++++
 tb/tb_sync_fifo_param.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable almost flags,
// overflow/underflow pulses, synchronous flush and optional first-word-fall-through reads.
module sync_fifo_param #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AF_LEVEL = 12,
    parameter int unsigned AE_LEVEL = 4,
    parameter int unsigned FWFT     = 0,
    localparam int unsigned ADDR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] din,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W:0] AF_CNT = AF_LEVEL[ADDR_W:0];
    localparam logic [ADDR_W:0] AE_CNT = AE_LEVEL[ADDR_W:0];

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic [ADDR_W:0]   cnt_q;
    logic [ADDR_W:0]   cnt_d;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              wr_acc;
    logic              rd_acc;
    logic              ovf_q;
    logic              udf_q;

    assign wr_addr = wr_ptr[ADDR_W-1:0];
    assign rd_addr = rd_ptr[ADDR_W-1:0];

    // Decisions use pre-edge flags only: no write-through when empty, no read-through when full.
    assign full   = (wr_addr == rd_addr) && (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
    assign empty  = (wr_ptr == rd_ptr);
    assign wr_acc = wr_en && !full && !clr;
    assign rd_acc = rd_en && !empty && !clr;

    assign almost_full  = (cnt_q >= AF_CNT);
    assign almost_empty = (cnt_q <= AE_CNT);
    assign count        = cnt_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    always_comb begin
        cnt_d = cnt_q;
        unique case ({wr_acc, rd_acc})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            cnt_q <= cnt_d;
            ovf_q <= wr_en && full;
            udf_q <= rd_en && empty;
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_addr] <= din;
    end

    if (FWFT != 0) begin : g_fwft
        assign dout = mem[rd_addr];
    end else begin : g_std
        logic [DATA_W-1:0] dout_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dout_q <= '0;
            end else if (rd_acc) begin
                dout_q <= mem[rd_addr];
            end
        end

        assign dout = dout_q;
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: vector table, scoreboard-checked random traffic,
// and hand-written flush, reset and FWFT sequences.
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr, wr_en, rd_en;
    logic [7:0] din, dout;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0] count;

    logic       f_wr_en, f_rd_en;
    logic [7:0] f_din, f_dout;
    logic       f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
    logic [4:0] f_count;

    int errors = 0;
    int checks = 0;

    logic [7:0] mdl[$];
    logic [7:0] exp_rd[$];
    logic [7:0] last_dout;

    typedef struct {
        bit         wr;
        bit         rd;
        logic [7:0] din;
        int         exp_count;
        bit         exp_ovf;
        bit         exp_udf;
        logic [7:0] exp_dout;
    } vec_t;

    vec_t vecs[34];

    sync_fifo_param #(
        .DATA_W(8), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(dout), .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
    );

    sync_fifo_param #(
        .DATA_W(8), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(1)
    ) dut_fwft (
        .clk(clk), .rst_n(rst_n), .clr(1'b0), .wr_en(f_wr_en), .din(f_din), .rd_en(f_rd_en),
        .dout(f_dout), .full(f_full), .empty(f_empty), .almost_full(f_af),
        .almost_empty(f_ae), .count(f_count), .overflow(f_ovf), .underflow(f_udf)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the queue model predicts every output of the FWFT=0 instance.
    task automatic step(input bit w, input logic [7:0] d, input bit r, input bit c);
        int n;
        bit aw, ar, eo, eu;
        n  = mdl.size();
        aw = w && !c && (n != 16);
        ar = r && !c && (n != 0);
        eo = w && !c && (n == 16);
        eu = r && !c && (n == 0);
        if (c) begin
            mdl.delete();
        end else begin
            if (ar) exp_rd.push_back(mdl.pop_front());
            if (aw) mdl.push_back(d);
        end
        wr_en = w; din = d; rd_en = r; clr = c;
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
        n = mdl.size();
        chk("count", 32'(count), 32'(n));
        chk("full", 32'(full), 32'(n == 16));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("almost_full", 32'(almost_full), 32'(n >= 12));
        chk("almost_empty", 32'(almost_empty), 32'(n <= 4));
        chk("overflow", 32'(overflow), 32'(eo));
        chk("underflow", 32'(underflow), 32'(eu));
        if (ar) last_dout = exp_rd.pop_front();
        chk("dout", 32'(dout), 32'(last_dout));
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            vecs[i] = '{wr: 1'b1, rd: 1'b0, din: 8'(i + 1), exp_count: i + 1,
                        exp_ovf: 1'b0, exp_udf: 1'b0, exp_dout: 8'h00};
        end
        vecs[16] = '{wr: 1'b1, rd: 1'b0, din: 8'hAA, exp_count: 16,
                     exp_ovf: 1'b1, exp_udf: 1'b0, exp_dout: 8'h00};
        for (int i = 0; i < 16; i++) begin
            vecs[17 + i] = '{wr: 1'b0, rd: 1'b1, din: 8'h00, exp_count: 15 - i,
                             exp_ovf: 1'b0, exp_udf: 1'b0, exp_dout: 8'(i + 1)};
        end
        vecs[33] = '{wr: 1'b0, rd: 1'b1, din: 8'h00, exp_count: 0,
                     exp_ovf: 1'b0, exp_udf: 1'b1, exp_dout: 8'h10};

        rst_n = 1'b0; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = '0;
        f_wr_en = 1'b0; f_rd_en = 1'b0; f_din = '0;
        last_dout = '0;
        #12;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_ae", 32'(almost_empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_af", 32'(almost_full), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_flags", 32'({overflow, underflow}), 32'd0);
        rst_n = 1'b1;

        // Fill, overflow attempt, drain in order, underflow attempt.
        for (int i = 0; i < 34; i++) begin
            step(vecs[i].wr, vecs[i].din, vecs[i].rd, 1'b0);
            chk("vec_count", 32'(count), 32'(vecs[i].exp_count));
            chk("vec_ovf", 32'(overflow), 32'(vecs[i].exp_ovf));
            chk("vec_udf", 32'(underflow), 32'(vecs[i].exp_udf));
            chk("vec_dout", 32'(dout), 32'(vecs[i].exp_dout));
        end
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("udf_one_cycle", 32'(underflow), 32'd0);

        // Simultaneous read/write at the full and empty boundaries.
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        step(1'b1, 8'hAB, 1'b1, 1'b0);
        chk("full_rw_count", 32'(count), 32'd15);
        chk("full_rw_ovf", 32'(overflow), 32'd1);
        chk("full_rw_dout", 32'(dout), 32'h30);
        while (mdl.size() != 0) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'hC3, 1'b1, 1'b0);
        chk("empty_rw_count", 32'(count), 32'd1);
        chk("empty_rw_udf", 32'(underflow), 32'd1);

        // Random traffic with alternating write-heavy and read-heavy phases.
        for (int i = 0; i < 1000; i++) begin
            bit w, r;
            if (((i / 40) % 2) == 0) begin
                w = ($urandom_range(0, 3) != 0);
                r = ($urandom_range(0, 3) == 0);
            end else begin
                w = ($urandom_range(0, 3) == 0);
                r = ($urandom_range(0, 3) != 0);
            end
            step(w, 8'($urandom), r, 1'b0);
        end

        // Flush with a concurrent write.
        while (mdl.size() != 0) step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b0, 1'b1);
        chk("clr_count", 32'(count), 32'd0);
        chk("clr_empty", 32'(empty), 32'd1);
        chk("clr_ovf", 32'(overflow), 32'd0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // First-word-fall-through instance.
        f_wr_en = 1'b1; f_din = 8'h5A;
        @(posedge clk); #1;
        f_wr_en = 1'b0;
        chk("fwft_empty", 32'(f_empty), 32'd0);
        chk("fwft_dout", 32'(f_dout), 32'h5A);
        f_wr_en = 1'b1; f_din = 8'h77;
        @(posedge clk); #1;
        f_wr_en = 1'b0;
        chk("fwft_head_held", 32'(f_dout), 32'h5A);
        f_rd_en = 1'b1;
        @(posedge clk); #1;
        chk("fwft_pop_next", 32'(f_dout), 32'h77);
        @(posedge clk); #1;
        f_rd_en = 1'b0;
        chk("fwft_pop_empty", 32'(f_empty), 32'd1);
        chk("fwft_count", 32'(f_count), 32'd0);

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h90 + i), (i > 2), 1'b0);
        wr_en = 1'b1; din = 8'h99; rd_en = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_ae", 32'(almost_empty), 32'd1);
        chk("mid_rst_dout", 32'(dout), 32'd0);
        chk("mid_rst_err", 32'({overflow, underflow, full, almost_full}), 32'd0);
        wr_en = 1'b0; rd_en = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        mdl.delete();
        exp_rd.delete();
        last_dout = '0;
        step(1'b1, 8'h42, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
